present_slayer_serial: RTL

- Nibble-serial PRESENT substitution layer plus optional permutation layer.
- Sits directly upstream of the 4-bit `sbox` cell. It takes a 64-bit cipher state and feeds the 16 nibbles one per cycle into the S-box.
- It collects the S-box outputs into a result register, optionally applies pLayer, and presents the 64-bit result through a valid/ready handshake.
- This gives the round datapath a single shared S-box: area over throughput.

---
 rtl/present_slayer_serial_pkg.sv | 24 ++
 rtl/present_slayer_serial_if.sv | 22 ++
 rtl/present_slayer_serial.sv | 96 +++++++++
 3 files changed

// File: rtl/present_slayer_serial_pkg.sv
// Shared PRESENT definitions: state geometry, serial FSM states and the pLayer bit permutation.
package present_slayer_serial_pkg;

  localparam int unsigned STATE_W = 64;
  localparam int unsigned NIBBLES = 16;
  localparam int unsigned NIB_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  // Bit i moves to 16*(i mod 4) + i/4; bit 63 maps onto itself under the same formula.
  function automatic logic [STATE_W-1:0] p_layer(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < STATE_W; i++) begin
      r[(i % 4) * 16 + (i / 4)] = s[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/present_slayer_serial_if.sv
// Valid/ready handshake bundle carrying the 64-bit state into and out of the serial S-layer.
interface present_slayer_serial_if;
  import present_slayer_serial_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_state;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_state;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );

endinterface

// File: rtl/present_slayer_serial.sv
// Nibble-serial PRESENT substitution layer around one shared external S-box, optional pLayer on output.
module present_slayer_serial
  import present_slayer_serial_pkg::*;
#(
  parameter bit PLAYER = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  present_slayer_serial_if.slave    bus,
  output logic [NIB_W-1:0]          sbox_in,
  input  logic [NIB_W-1:0]          sbox_out,
  output logic                      busy,
  output logic [NIB_W-1:0]          nib_idx
);

  fsm_state_e         state_q,     state_d;
  logic [STATE_W-1:0] state_reg_q, state_reg_d;
  logic [STATE_W-1:0] result_q,    result_d;
  logic [STATE_W-1:0] out_state_q, out_state_d;
  logic [NIB_W-1:0]   nib_idx_q,   nib_idx_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q,      busy_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      state_reg_q <= '0;
      result_q    <= '0;
      out_state_q <= '0;
      nib_idx_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      state_reg_q <= state_reg_d;
      result_q    <= result_d;
      out_state_q <= out_state_d;
      nib_idx_q   <= nib_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    state_reg_d = state_reg_q;
    result_d    = result_q;
    nib_idx_d   = nib_idx_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_reg_d = bus.in_state;
          nib_idx_d   = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        result_d[{nib_idx_q, 2'b00} +: NIB_W] = sbox_out;
        nib_idx_d = nib_idx_q + NIB_W'(1);
        if (nib_idx_q == NIB_W'(NIBBLES - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs follow the next state; the result is captured on DONE entry only
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d == RUN);
    out_valid_d = (state_d == DONE);
    out_state_d = out_state_q;
    if ((state_q == RUN) && (state_d == DONE)) begin
      out_state_d = PLAYER ? p_layer(result_d) : result_d;
    end
    sbox_in = (state_q == RUN) ? state_reg_q[{nib_idx_q, 2'b00} +: NIB_W] : '0;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = out_state_q;
  assign busy          = busy_q;
  assign nib_idx       = nib_idx_q;

endmodule
